// File: rtl/multicycle_controller.sv
// Five-phase sequencer for the 16-bit SIMPLE core: run/stop/step control,
// memory handshake with stall timeout, branch resolution and retire counter.
module multicycle_controller #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             step,
  input  logic [15:0]      instr,
  input  logic [3:0]       flags,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             FlagWrite,
  output logic             OutEn,
  output logic [4:0]       phase,
  output logic             running,
  output logic             Halt,
  output logic             fault,
  output logic [CNT_W-1:0] icount
);

  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_P1    = 3'd1,
    ST_P2    = 3'd2,
    ST_P3    = 3'd3,
    ST_P4    = 3'd4,
    ST_P5    = 3'd5,
    ST_HALT  = 3'd6,
    ST_FAULT = 3'd7
  } state_t;

  state_t            state_r;
  logic              stop_pending_r;
  logic              armed_r;
  logic              exec_d_r;
  logic              step_d_r;
  logic [WAIT_W-1:0] wait_r;
  logic [CNT_W-1:0]  icount_r;

  logic [1:0] op1_s;
  logic [2:0] op2_s;
  logic [2:0] cond_s;
  logic [3:0] op3_s;
  logic       is_ld_s, is_st_s, is_li_s, is_addi_s, is_b_s, is_bc_s, is_alu_s, is_hlt_s;
  logic       alu_regwr_s, alu_flagwr_s, taken_s;
  logic       exec_edge_s, step_edge_s, stall_s, timeout_s, busy_s;
  logic       unused_ok_s;

  assign op1_s  = instr[15:14];
  assign op2_s  = instr[13:11];
  assign cond_s = instr[10:8];
  assign op3_s  = instr[7:4];

  assign is_ld_s   = (op1_s == 2'b00);
  assign is_st_s   = (op1_s == 2'b01);
  assign is_li_s   = (op1_s == 2'b10) && (op2_s == 3'b000);
  assign is_addi_s = (op1_s == 2'b10) && (op2_s == 3'b001);
  assign is_b_s    = (op1_s == 2'b10) && (op2_s == 3'b100);
  assign is_bc_s   = (op1_s == 2'b10) && (op2_s == 3'b111);
  assign is_alu_s  = (op1_s == 2'b11);
  assign is_hlt_s  = is_alu_s && (op3_s == 4'b1111);

  // CMP, OUT, NOP and HLT leave the register file untouched
  assign alu_regwr_s  = is_alu_s && (op3_s != 4'b0101) && (op3_s != 4'b1101)
                        && (op3_s != 4'b1110) && (op3_s != 4'b1111);
  assign alu_flagwr_s = is_alu_s && (op3_s <= 4'b1011);

  // The first clock after reset release only primes the edge detectors
  assign exec_edge_s = armed_r && exec && !exec_d_r;
  assign step_edge_s = armed_r && step && !step_d_r;

  assign busy_s    = (state_r == ST_P1) || (state_r == ST_P2) || (state_r == ST_P3)
                     || (state_r == ST_P4) || (state_r == ST_P5);
  assign stall_s   = mem_req && !mem_ready;
  assign timeout_s = (WAIT_LIMIT > 0) && stall_s && (wait_r == WAIT_W'(WAIT_LIMIT - 1));

  assign icount      = icount_r;
  assign unused_ok_s = ^{instr[3:0], flags[1]};

  // Branch condition from {S,Z,C,V}
  always_comb begin
    taken_s = 1'b0;
    case (cond_s)
      3'b000:  taken_s = flags[2];
      3'b001:  taken_s = flags[3] ^ flags[0];
      3'b010:  taken_s = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  taken_s = !flags[2];
      default: taken_s = 1'b0;
    endcase
  end

  // Datapath strobes decoded from the current phase and instruction
  always_comb begin
    mem_req   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    FlagWrite = 1'b0;
    OutEn     = 1'b0;
    case (state_r)
      ST_P1: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_P3: begin
        ALUSrc    = is_ld_s || is_st_s || is_addi_s;
        FlagWrite = alu_flagwr_s || is_addi_s;
      end
      ST_P4: begin
        if (is_ld_s) begin
          mem_req = 1'b1;
          MemRead = 1'b1;
        end else if (is_st_s) begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
        end else if (is_b_s) begin
          PCSrc   = 1'b1;
          PCWrite = 1'b1;
        end else if (is_bc_s) begin
          PCSrc   = taken_s;
          PCWrite = taken_s;
        end else begin
          PCSrc = 1'b0;
        end
      end
      ST_P5: begin
        RegWrite = is_ld_s || is_li_s || is_addi_s || alu_regwr_s;
        MemtoReg = is_ld_s;
        RegDst   = !is_ld_s;
        OutEn    = is_alu_s && (op3_s == 4'b1101);
      end
      default: mem_req = 1'b0;
    endcase
  end

  // Status decode of the state register
  always_comb begin
    phase   = 5'b00000;
    running = busy_s && !stop_pending_r;
    Halt    = (state_r == ST_HALT);
    fault   = (state_r == ST_FAULT);
    case (state_r)
      ST_P1:   phase = 5'b00001;
      ST_P2:   phase = 5'b00010;
      ST_P3:   phase = 5'b00100;
      ST_P4:   phase = 5'b01000;
      ST_P5:   phase = 5'b10000;
      default: phase = 5'b00000;
    endcase
  end

  // Phase sequencer, run/stop control, stall timer and retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_STOP;
      stop_pending_r <= 1'b0;
      armed_r        <= 1'b0;
      exec_d_r       <= 1'b0;
      step_d_r       <= 1'b0;
      wait_r         <= '0;
      icount_r       <= '0;
    end else begin
      armed_r  <= 1'b1;
      exec_d_r <= exec;
      step_d_r <= step;
      wait_r   <= stall_s ? (wait_r + WAIT_W'(1)) : '0;
      if (busy_s && exec_edge_s) begin
        stop_pending_r <= 1'b1;
      end
      case (state_r)
        ST_STOP: begin
          if (exec_edge_s) begin
            stop_pending_r <= 1'b0;
            state_r        <= ST_P1;
          end else if (step_edge_s) begin
            stop_pending_r <= 1'b1;
            state_r        <= ST_P1;
          end
        end
        ST_P1: begin
          if (timeout_s) begin
            state_r <= ST_FAULT;
          end else if (mem_ready) begin
            state_r <= ST_P2;
          end
        end
        ST_P2: state_r <= is_hlt_s ? ST_HALT : ST_P3;
        ST_P3: state_r <= ST_P4;
        ST_P4: begin
          if (is_ld_s || is_st_s) begin
            if (timeout_s) begin
              state_r <= ST_FAULT;
            end else if (mem_ready) begin
              state_r <= ST_P5;
            end
          end else begin
            state_r <= ST_P5;
          end
        end
        ST_P5: begin
          icount_r <= icount_r + CNT_W'(1);
          state_r  <= (stop_pending_r || exec_edge_s) ? ST_STOP : ST_P1;
        end
        ST_HALT:  state_r <= ST_HALT;
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_FAULT;
      endcase
    end
  end

endmodule
